// File: rtl/onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// onehot_decoder_seq
//
// Purpose:
//    Sequenced 4-to-16 one-hot decoder. It accepts a 4-bit line index over a
//    valid/ready handshake. It then drives the selected line of D for HOLD
//    cycles, and follows that with exactly one all-zero GAP cycle. Because of
//    the gap, D can feed a 16:1 priority encoder directly: consecutive codes
//    never overlap and never change from one nonzero code to another.
//
// Parameters:
//    HOLD      cycles D stays asserted per transaction (legal 1..255)
//
// Ports:
//    clk       input   1   single clock, rising edge
//    rst_n     input   1   synchronous active-low reset
//    in_valid  input   1   upstream request
//    in_idx    input   4   line index to assert
//    in_en     input   1   1: decode in_idx, 0: run the transaction with D=0
//    in_ready  output  1   high in IDLE only
//    D         output 16   one-hot (or all-zero) output, decoded from state
//    busy      output  1   high whenever not IDLE
//    done      output  1   one-cycle pulse in the GAP cycle
//    drop_cnt  output  8   saturating count of in_valid && !in_ready cycles
// -----------------------------------------------------------------------------
module onehot_decoder_seq #(
   parameter int unsigned HOLD = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [3:0]  in_idx,
   input  logic        in_en,
   output logic        in_ready,
   output logic [15:0] D,
   output logic        busy,
   output logic        done,
   output logic [7:0]  drop_cnt
);

   localparam int unsigned CW = $clog2(HOLD + 1);
   localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_idx;
   logic          r_en;
   logic [7:0]    r_drop_cnt;

   logic          w_accept;
   logic          w_drive;
   logic          w_ready;
   logic [15:0]   w_d;

   // Handshake outputs depend on state only, never on the inputs.
   assign w_ready  = (r_state == S_IDLE);
   assign w_accept = in_valid && w_ready;
   assign w_drive  = (r_state == S_DRIVE);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = S_DRIVE;
            end
         end
         S_DRIVE: begin
            // The counter is loaded with HOLD-1, so reaching zero marks the
            // last of the HOLD drive cycles.
            if (r_cnt == '0) begin
               w_state_next = S_GAP;
            end
         end
         S_GAP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Hold counter and request latch. in_idx and in_en are sampled only on the
   // accept edge, so upstream may change them while a transaction runs.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= 4'h0;
         r_en  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt <= HOLD_M1;
            r_idx <= in_idx;
            r_en  <= in_en;
         end else if (w_drive && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Drop counter: each cycle a request is presented but cannot be taken.
   // Requests are not queued. It saturates rather than wrapping.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_drop_cnt <= 8'h00;
      end else if (in_valid && !w_ready && (r_drop_cnt != 8'hFF)) begin
         r_drop_cnt <= r_drop_cnt + 8'h01;
      end
   end

   // -------------------------------------------------------------------------
   // One-hot decode. Each line compares against its own index, so at most one
   // bit can be high. The whole word is gated by DRIVE, which makes the GAP
   // and IDLE cycles all-zero.
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_line
         assign w_d[gi] = w_drive && r_en && (r_idx == 4'(gi));
      end
   endgenerate

   assign D        = w_d;
   assign in_ready = w_ready;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_GAP);
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
`timescale 1ns/1ps
module tb_onehot_decoder_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  in_idx;
   logic        in_en;
   logic        in_ready;
   logic [15:0] D;
   logic        busy;
   logic        done;
   logic [7:0]  drop_cnt;

   integer checks = 0;
   integer errors = 0;

   always #5 clk = ~clk;

   onehot_decoder_seq #(.HOLD(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_idx   (in_idx),
      .in_en    (in_en),
      .in_ready (in_ready),
      .D        (D),
      .busy     (busy),
      .done     (done),
      .drop_cnt (drop_cnt)
   );

   // Outputs are sampled 1 ns after the rising edge, and inputs change there.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference 16:1 priority encoder (highest set bit wins).
   function automatic logic [3:0] enc(input logic [15:0] d);
      logic [3:0] y;
      y = 4'h0;
      for (int i = 0; i < 16; i++) if (d[i]) y = i[3:0];
      return y;
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b1; in_idx = 4'h2; in_en = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick;
         checks++;
         if (D !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || drop_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_state c%0d: D=%h rdy=%b busy=%b done=%b drop=%h, need D=0000 rdy=1 busy=0 done=0 drop=00",
                     c, D, in_ready, busy, done, drop_cnt);
         end
      end
      in_valid = 1'b0; rst_n = 1'b1;
      tick;
      checks++;
      if (busy !== 1'b0 || D !== 16'h0000) begin
         errors++;
         $display("FAIL reset_no_accept: busy=%b D=%h, need busy=0 D=0000", busy, D);
      end
      $display("test_reset: done");
   endtask

   task automatic test_single;
      in_idx = 4'hA; in_en = 1'b1; in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready_c0: in_ready=%b, need 1", in_ready);
      end
      tick;
      // Changes after the accept edge must not affect the transaction.
      in_valid = 1'b0; in_idx = 4'h5; in_en = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (D !== 16'h0400) begin
            errors++;
            $display("FAIL single_D c%0d: D=%h, need 0400", c, D);
         end
         checks++;
         if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL single_ctl c%0d: busy=%b rdy=%b done=%b, need 1 0 0", c, busy, in_ready, done);
         end
         tick;
      end
      checks++;
      if (D !== 16'h0000 || done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_gap c5: D=%h done=%b busy=%b rdy=%b, need 0000 1 1 0", D, done, busy, in_ready);
      end
      tick;
      checks++;
      if (in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || D !== 16'h0000 || drop_cnt !== 8'h00) begin
         errors++;
         $display("FAIL single_idle c6: rdy=%b done=%b busy=%b D=%h drop=%h, need 1 0 0 0000 00",
                  in_ready, done, busy, D, drop_cnt);
      end
      $display("test_single: idx=A D=0400 x4 then gap");
   endtask

   task automatic test_sweep;
      logic [15:0] exp_d;
      for (int i = 0; i < 16; i++) begin
         exp_d = 16'h0001 << i;
         in_idx = i[3:0]; in_en = 1'b1; in_valid = 1'b1;
         tick;
         in_valid = 1'b0;
         for (int c = 1; c <= 6; c++) begin
            checks++;
            if ($countones(D) > 1) begin
               errors++;
               $display("FAIL sweep_onehot idx%0d c%0d: D=%h, need popcount<=1", i, c, D);
            end
            if (c <= 4) begin
               checks++;
               if (D !== exp_d || enc(D) !== i[3:0]) begin
                  errors++;
                  $display("FAIL sweep_drive idx%0d c%0d: D=%h Y=%h, need D=%h Y=%h", i, c, D, enc(D), exp_d, i[3:0]);
               end
            end else begin
               checks++;
               if (D !== 16'h0000) begin
                  errors++;
                  $display("FAIL sweep_zero idx%0d c%0d: D=%h, need 0000", i, c, D);
               end
            end
            if (c < 6) tick;
         end
         $display("test_sweep: idx=%0d decoded", i);
      end
   endtask

   task automatic test_en0;
      in_idx = 4'hF; in_en = 1'b0; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         checks++;
         if (D !== 16'h0000 || busy !== 1'b1 || done !== (c == 5)) begin
            errors++;
            $display("FAIL en0 c%0d: D=%h busy=%b done=%b, need 0000 1 %b", c, D, busy, done, (c == 5));
         end
         tick;
      end
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL en0_idle c6: busy=%b rdy=%b, need 0 1", busy, in_ready);
      end
      $display("test_en0: D stayed zero, done at cycle 5");
   endtask

   task automatic test_back_to_back;
      int          ph;
      logic [7:0]  exp_drop;
      rst_n = 1'b0; in_valid = 1'b0;
      tick;
      rst_n = 1'b1;
      in_idx = 4'h7; in_en = 1'b1; in_valid = 1'b1;
      exp_drop = 8'h00;
      for (int c = 0; c < 320; c++) begin
         ph = c % 6;
         checks++;
         if (in_ready !== (ph == 0) || done !== (ph == 5) || drop_cnt !== exp_drop ||
             D !== ((ph >= 1 && ph <= 4) ? 16'h0080 : 16'h0000)) begin
            errors++;
            $display("FAIL b2b c%0d: rdy=%b done=%b D=%h drop=%h, need rdy=%b done=%b drop=%h",
                     c, in_ready, done, D, drop_cnt, (ph == 0), (ph == 5), exp_drop);
         end
         if (ph != 0 && exp_drop != 8'hFF) exp_drop = exp_drop + 8'h01;
         tick;
      end
      in_valid = 1'b0;
      checks++;
      if (drop_cnt !== 8'hFF) begin
         errors++;
         $display("FAIL b2b_saturate: drop=%h, need FF", drop_cnt);
      end
      for (int c = 0; c < 6; c++) tick;
      checks++;
      if (drop_cnt !== 8'hFF || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_hold: drop=%h busy=%b, need FF 0", drop_cnt, busy);
      end
      $display("test_back_to_back: 320 cycles, drop_cnt=%h", drop_cnt);
   endtask

   task automatic test_reset_abort;
      rst_n = 1'b0; in_valid = 1'b0;
      tick;
      rst_n = 1'b1;
      in_idx = 4'h3; in_en = 1'b1; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      checks++;
      if (D !== 16'h0008) begin
         errors++;
         $display("FAIL abort_drive2: D=%h, need 0008", D);
      end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      checks++;
      if (D !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset: D=%h rdy=%b busy=%b done=%b, need 0000 1 0 0", D, in_ready, busy, done);
      end
      for (int c = 0; c < 6; c++) begin
         tick;
         checks++;
         if (done !== 1'b0 || D !== 16'h0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_after c%0d: done=%b D=%h rdy=%b, need 0 0000 1", c, done, D, in_ready);
         end
      end
      $display("test_reset_abort: transaction aborted, no done");
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_idx = 4'h0; in_en = 1'b0;
      test_reset;
      test_single;
      test_sweep;
      test_en0;
      test_back_to_back;
      test_reset_abort;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
